// File: rtl/cpu_control_seq_if.sv
// Memory handshake and control-word bundle between the control sequencer
// (master) and the accumulator datapath/memory side (slave).
interface cpu_control_seq_if;
  // MEM_RDY is a single-cycle completion strobe for the access the sequencer
  // is currently holding in CON. There is no request/ack pairing: the access
  // counts as done on any posedge where MEM_RDY=1 while a wait state is active.
  logic        MEM_RDY;
  logic [7:0]  IR_IN;
  logic        ACC_NEG;
  logic [31:0] CON;

  modport master (input MEM_RDY, input IR_IN, input ACC_NEG, output CON);
  modport slave  (output MEM_RDY, output IR_IN, output ACC_NEG, input CON);
endinterface

// File: rtl/cpu_control_seq.sv
// Hardwired fetch/decode/execute sequencer for the accumulator CPU.
// All outputs are registered; CON always matches the state shown on STATE.
module cpu_control_seq #(
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 16
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               START,
  cpu_control_seq_if.master  bus,
  output logic [3:0]         STATE,
  output logic               HALTED,
  output logic               FAULT,
  output logic               ILLEGAL,
  output logic [CNT_W-1:0]   INSTR_CNT
);

  typedef enum logic [3:0] {
    S_IDLE = 4'd0, S_F0 = 4'd1, S_F1 = 4'd2, S_F2 = 4'd3, S_DEC = 4'd4,
    S_RD = 4'd5, S_OP = 4'd6, S_ALU = 4'd7, S_ST0 = 4'd8, S_ST1 = 4'd9,
    S_JMP = 4'd10, S_HALT = 4'd11
  } state_t;

  localparam logic [7:0] OP_STORE  = 8'h01;
  localparam logic [7:0] OP_LOAD   = 8'h02;
  localparam logic [7:0] OP_ADD    = 8'h03;
  localparam logic [7:0] OP_SUB    = 8'h04;
  localparam logic [7:0] OP_JMPGEZ = 8'h05;
  localparam logic [7:0] OP_JMP    = 8'h06;
  localparam logic [7:0] OP_HALT   = 8'h07;

  localparam logic [7:0]       WAIT_LAST = 8'(MEM_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  state_t             state_q, state_d;
  logic [7:0]         wait_q, wait_d;
  logic [7:0]         op_q, op_d;
  logic [31:0]        con_q, con_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               fault_q, fault_d;
  logic               illegal_q, illegal_d;
  logic               halted_q;
  state_t             after_wait;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= S_IDLE;
      wait_q    <= '0;
      op_q      <= '0;
      con_q     <= '0;
      cnt_q     <= '0;
      fault_q   <= 1'b0;
      illegal_q <= 1'b0;
      halted_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      op_q      <= op_d;
      con_q     <= con_d;
      cnt_q     <= cnt_d;
      fault_q   <= fault_d;
      illegal_q <= illegal_d;
      halted_q  <= (state_d == S_HALT);
    end
  end

  always_comb begin
    state_d    = state_q;
    wait_d     = '0;
    op_d       = op_q;
    cnt_d      = cnt_q;
    fault_d    = fault_q;
    illegal_d  = 1'b0;
    con_d      = '0;
    after_wait = S_F0;

    case (state_q)
      S_F1:    after_wait = S_F2;
      S_RD:    after_wait = S_OP;
      default: after_wait = S_F0;
    endcase

    case (state_q)
      S_IDLE: if (START) state_d = S_F0;
      S_F0:   state_d = S_F1;
      // Shared memory wait: MEM_RDY takes priority over the timeout check.
      S_F1, S_RD, S_ST1: begin
        if (bus.MEM_RDY) begin
          state_d = after_wait;
        end else if (wait_q == WAIT_LAST) begin
          state_d = S_HALT;
          fault_d = 1'b1;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end
      S_F2:   state_d = S_DEC;
      S_DEC: begin
        cnt_d = cnt_q + CNT_ONE;
        op_d  = bus.IR_IN;
        case (bus.IR_IN)
          OP_LOAD, OP_ADD, OP_SUB: state_d = S_RD;
          OP_STORE:                state_d = S_ST0;
          OP_JMP:                  state_d = S_JMP;
          OP_JMPGEZ:               state_d = bus.ACC_NEG ? S_F0 : S_JMP;
          OP_HALT:                 state_d = S_HALT;
          default: begin
            state_d   = S_F0;
            illegal_d = 1'b1;
          end
        endcase
      end
      S_OP:   state_d = S_ALU;
      S_ALU:  state_d = S_F0;
      S_ST0:  state_d = S_ST1;
      S_JMP:  state_d = S_F0;
      S_HALT: state_d = S_HALT;
      default: state_d = S_IDLE;
    endcase

    // Control word is computed for the state being entered so it is
    // registered alongside that state.
    case (state_d)
      S_F0:  con_d[0] = 1'b1;
      S_F1:  con_d[1] = 1'b1;
      S_F2:  con_d[4:2] = 3'b111;
      S_RD:  con_d[1] = 1'b1;
      S_OP:  con_d[5] = 1'b1;
      S_ALU: begin
        case (op_q)
          OP_LOAD: con_d[12] = 1'b1;
          OP_ADD:  con_d[6]  = 1'b1;
          OP_SUB:  con_d[7]  = 1'b1;
          default: con_d     = '0;
        endcase
      end
      S_ST0: con_d[8]  = 1'b1;
      S_ST1: con_d[9]  = 1'b1;
      S_JMP: con_d[10] = 1'b1;
      default: con_d = '0;
    endcase
  end

  assign bus.CON   = con_q;
  assign STATE     = state_q;
  assign HALTED    = halted_q;
  assign FAULT     = fault_q;
  assign ILLEGAL   = illegal_q;
  assign INSTR_CNT = cnt_q;

endmodule
